brick_hit_detector: RTL and testbench
=====================================

# brick_hit_detector

Per-frame collision stage feeding `blocks_generator`. After each frame tick it scans all 25 targets (20 blocks b1–b20 and 5 rocks r1–r5), one target per cycle. It tests the ball's bounding box against each target's geometry and holds the sticky `collision_ball[24:0]` vector that removes hit targets from the playfield. It also issues one-cycle bounce requests to the ball-motion logic.

## Interface
- `N_TGT`, 25: number of targets; index 0–19 is b1–b20, 20–24 is r1–r5.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous reset, active-low (asserted at 0).
- `clear`  in  1  synchronous new-game clear; one-cycle pulse.
- `frame_tick`  in  1  one-cycle pulse per video frame; starts a scan.
- `ball_x`, `ball_y`  in  10 each  ball top-left corner, pixels.
- `ball_size`  in  10  ball edge length in pixels (square).
- `tgt_x`, `tgt_y`, `tgt_w`, `tgt_h`  in  10 each  geometry of target `tgt_idx`, supplied combinationally by the layout stage in the same cycle. `tgt_x` = 640 means the target is removed.
- `tgt_idx`  out  5  target currently being evaluated.
- `collision_ball`  out  25  sticky hit flags; bit i is target i.
- `hit_pulse`  out  1  one cycle high when a new target is hit this frame.
- `hit_idx`  out  5  index of the target hit; valid while `hit_pulse` = 1.
- `bounce_x`, `bounce_y`  out  1 each  one-cycle reflect request for the horizontal / vertical velocity component.
- `scan_busy`  out  1  high during SCAN.
- `hit_count`  out  5  number of set bits in `collision_ball`, 0–25.
- `all_cleared`  out  1  high while `hit_count` = 25.
- `overrun`  out  1  sticky; a `frame_tick` arrived while not IDLE.

## Operation
- The FSM has three states: IDLE, SCAN, DONE.
- IDLE → SCAN on `frame_tick`. On entry:
  - latch `ball_x`/`ball_y` into `cur_x`/`cur_y`;
  - move the previous `cur_*` values into `prev_x`/`prev_y`;
  - clear `found`;
  - set `tgt_idx` = 0.
- SCAN, evaluating target `tgt_idx`:
  - The target is skipped if `tgt_x` = 640 or `collision_ball[tgt_idx]` = 1.
  - Otherwise overlap is `cur_x < tgt_x+tgt_w` AND `cur_x+ball_size > tgt_x` AND `cur_y < tgt_y+tgt_h` AND `cur_y+ball_size > tgt_y`.
  - All sums are 11-bit unsigned, so there is no wrap.
  - If overlap is true and `found` = 0: set `found`, record `idx_r` = `tgt_idx`, and record the bounce axis.
  - Bounce axis is X if `prev_x+ball_size <= tgt_x` or `prev_x >= tgt_x+tgt_w`; otherwise Y.
  - At most one hit per frame is recorded: the lowest-index overlapping target.
  - `tgt_idx` increments each cycle. After evaluating index 24 → DONE.
- DONE (exactly one cycle):
  - If `found`: set `collision_ball[idx_r]`, increment `hit_count`, and pulse `hit_pulse`, `hit_idx`, and the selected `bounce_x` or `bounce_y`.
  - Then → IDLE.
- `frame_tick` in SCAN or DONE is ignored and sets `overrun`. Only `clear` or reset clears `overrun`.
- `clear` has the highest priority, from any state:
  - `collision_ball` = 0, `hit_count` = 0, `overrun` = 0;
  - all pulse outputs forced to 0;
  - `prev_*`/`cur_*` ← current ball position;
  - FSM → IDLE. No partial hit from an aborted scan is committed.
- `clear` and `frame_tick` in the same cycle: `clear` wins and the tick is dropped.
- With `all_cleared` = 1, scans still run; every target is skipped, so no hits occur.

## Timing
- Reset (`rst` = 0, asynchronous):
  - FSM = IDLE, `tgt_idx` = 0;
  - `collision_ball` = 0, `hit_count` = 0;
  - `hit_pulse`, `hit_idx`, `bounce_x`, `bounce_y` = 0;
  - `scan_busy` = 0, `all_cleared` = 0, `overrun` = 0;
  - `prev_*` = `cur_*` = 0.
- Reset asserted mid-scan aborts the scan immediately; nothing is committed.
- With `frame_tick` high in cycle T:
  - SCAN occupies cycles T+1 … T+25 with `tgt_idx` = 0 … 24 and `scan_busy` = 1;
  - DONE occurs in T+26, with the pulse outputs high in that cycle;
  - the new `collision_ball` bit and `hit_count` are visible from T+27;
  - IDLE from T+27, so the next tick is accepted at the earliest in T+27.
- All outputs except `tgt_idx` are registered. `tgt_idx` is the state register itself.
- The `tgt_*` inputs are required to settle combinationally within the cycle `tgt_idx` presents them.

## Test plan
- Reset, then ball at (0,0) size 8, `frame_tick` → `scan_busy` high for exactly 25 cycles; no pulses; `collision_ball` = 0.
- Target 3 at x=100, y=40, w=60, h=20; previous ball at (110,20); current ball at (110,36), size 8; tick → in T+26 `hit_pulse` = 1, `hit_idx` = 3, `bounce_y` = 1, `bounce_x` = 0; `collision_ball` = 25'h0000008 from T+27; `hit_count` = 1.
- Ball overlapping targets 5 and 21, approaching from the left (prev x beyond left edge) → only `hit_idx` = 5 is recorded, `bounce_x` = 1; a second tick with an unchanged ball then hits 21.
- Target with `tgt_x` = 640 that would overlap if present → no hit. A repeated tick on an already-set bit → no second `hit_pulse`, and `hit_count` is unchanged.
- `frame_tick` at T+10 of a scan → ignored; `overrun` = 1; scan ends at T+26 as normal. Then `clear` → all flags 0, `overrun` = 0, FSM IDLE.
- Drive 25 successive frames, each hitting a new target → `hit_count` = 25, `all_cleared` = 1. Then `clear` together with `frame_tick` → `all_cleared` = 0 and no scan starts.

Source files
------------

// File: rtl/brick_hit_detector.sv
// Per-frame ball/target collision scanner: walks all targets once per frame tick,
// records the lowest-index new hit, and commits it with a one-cycle bounce request.
module brick_hit_detector #(
  parameter int unsigned N_TGT = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             frame_tick,
  input  logic [9:0]       ball_x,
  input  logic [9:0]       ball_y,
  input  logic [9:0]       ball_size,
  input  logic [9:0]       tgt_x,
  input  logic [9:0]       tgt_y,
  input  logic [9:0]       tgt_w,
  input  logic [9:0]       tgt_h,
  output logic [4:0]       tgt_idx,
  output logic [N_TGT-1:0] collision_ball,
  output logic             hit_pulse,
  output logic [4:0]       hit_idx,
  output logic             bounce_x,
  output logic             bounce_y,
  output logic             scan_busy,
  output logic [4:0]       hit_count,
  output logic             all_cleared,
  output logic             overrun
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e     state_q;
  logic [9:0] cur_x_q, cur_y_q, prev_x_q, prev_y_q;
  logic       found_q, axis_x_q;
  logic [4:0] idx_q;

  logic [10:0] tx, ty, tx_end, ty_end, cx, cy, cx_end, cy_end, px, px_end;
  logic        skip, overlap, hit, take, axis_x;
  logic        found_n, axis_n, last;
  logic [4:0]  idx_n;

  always_comb begin
    tx      = {1'b0, tgt_x};
    ty      = {1'b0, tgt_y};
    tx_end  = {1'b0, tgt_x} + {1'b0, tgt_w};
    ty_end  = {1'b0, tgt_y} + {1'b0, tgt_h};
    cx      = {1'b0, cur_x_q};
    cy      = {1'b0, cur_y_q};
    cx_end  = {1'b0, cur_x_q} + {1'b0, ball_size};
    cy_end  = {1'b0, cur_y_q} + {1'b0, ball_size};
    px      = {1'b0, prev_x_q};
    px_end  = {1'b0, prev_x_q} + {1'b0, ball_size};
    skip    = (tgt_x == 10'd640) || collision_ball[tgt_idx];
    overlap = (cx < tx_end) && (cx_end > tx) && (cy < ty_end) && (cy_end > ty);
    hit     = (state_q == StScan) && !skip && overlap;
    // Ball was fully beside the target last frame: it came in through a vertical edge.
    axis_x  = (px_end <= tx) || (px >= tx_end);
    take    = hit && !found_q;
    found_n = found_q | hit;
    idx_n   = take ? tgt_idx : idx_q;
    axis_n  = take ? axis_x : axis_x_q;
    last    = (tgt_idx == 5'(N_TGT - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      tgt_idx        <= '0;
      cur_x_q        <= '0;
      cur_y_q        <= '0;
      prev_x_q       <= '0;
      prev_y_q       <= '0;
      found_q        <= 1'b0;
      axis_x_q       <= 1'b0;
      idx_q          <= '0;
      collision_ball <= '0;
      hit_count      <= '0;
      hit_pulse      <= 1'b0;
      hit_idx        <= '0;
      bounce_x       <= 1'b0;
      bounce_y       <= 1'b0;
      scan_busy      <= 1'b0;
      all_cleared    <= 1'b0;
      overrun        <= 1'b0;
    end else if (clear) begin
      state_q        <= StIdle;
      tgt_idx        <= '0;
      cur_x_q        <= ball_x;
      cur_y_q        <= ball_y;
      prev_x_q       <= ball_x;
      prev_y_q       <= ball_y;
      found_q        <= 1'b0;
      collision_ball <= '0;
      hit_count      <= '0;
      hit_pulse      <= 1'b0;
      hit_idx        <= '0;
      bounce_x       <= 1'b0;
      bounce_y       <= 1'b0;
      scan_busy      <= 1'b0;
      all_cleared    <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      hit_idx   <= '0;
      bounce_x  <= 1'b0;
      bounce_y  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (frame_tick) begin
            prev_x_q  <= cur_x_q;
            prev_y_q  <= cur_y_q;
            cur_x_q   <= ball_x;
            cur_y_q   <= ball_y;
            found_q   <= 1'b0;
            tgt_idx   <= '0;
            scan_busy <= 1'b1;
            state_q   <= StScan;
          end
        end
        StScan: begin
          if (frame_tick) overrun <= 1'b1;
          found_q  <= found_n;
          idx_q    <= idx_n;
          axis_x_q <= axis_n;
          if (last) begin
            // Pulses go out in the DONE cycle, so they include the final target's result.
            tgt_idx   <= '0;
            scan_busy <= 1'b0;
            hit_pulse <= found_n;
            hit_idx   <= found_n ? idx_n : 5'd0;
            bounce_x  <= found_n & axis_n;
            bounce_y  <= found_n & ~axis_n;
            state_q   <= StDone;
          end else begin
            tgt_idx <= tgt_idx + 5'd1;
          end
        end
        StDone: begin
          if (frame_tick) overrun <= 1'b1;
          if (found_q) begin
            collision_ball[idx_q] <= 1'b1;
            hit_count             <= hit_count + 5'd1;
            all_cleared           <= (hit_count == 5'(N_TGT - 1));
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_brick_hit_detector.sv
// Directed bench for brick_hit_detector with a table-driven target layout model.
module tb_brick_hit_detector;

  logic        clk, rst, clear, frame_tick;
  logic [9:0]  ball_x, ball_y, ball_size;
  logic [9:0]  tgt_x, tgt_y, tgt_w, tgt_h;
  logic [4:0]  tgt_idx, hit_idx, hit_count;
  logic [24:0] collision_ball;
  logic        hit_pulse, bounce_x, bounce_y, scan_busy, all_cleared, overrun;

  logic [9:0] tx [25];
  logic [9:0] ty [25];
  logic [9:0] tw [25];
  logic [9:0] th [25];

  int total = 0;
  int bad   = 0;

  brick_hit_detector #(.N_TGT(25)) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .frame_tick    (frame_tick),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .ball_size     (ball_size),
    .tgt_x         (tgt_x),
    .tgt_y         (tgt_y),
    .tgt_w         (tgt_w),
    .tgt_h         (tgt_h),
    .tgt_idx       (tgt_idx),
    .collision_ball(collision_ball),
    .hit_pulse     (hit_pulse),
    .hit_idx       (hit_idx),
    .bounce_x      (bounce_x),
    .bounce_y      (bounce_y),
    .scan_busy     (scan_busy),
    .hit_count     (hit_count),
    .all_cleared   (all_cleared),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (tgt_idx < 5'd25) begin
      tgt_x = tx[tgt_idx];
      tgt_y = ty[tgt_idx];
      tgt_w = tw[tgt_idx];
      tgt_h = th[tgt_idx];
    end else begin
      tgt_x = 10'd640;
      tgt_y = 10'd0;
      tgt_w = 10'd0;
      tgt_h = 10'd0;
    end
  end

  task automatic clear_layout();
    for (int i = 0; i < 25; i++) begin
      tx[i] = 10'd640;
      ty[i] = 10'd0;
      tw[i] = 10'd0;
      th[i] = 10'd0;
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Tick in cycle T, observe T+1..T+26, return at T+27 (negedge sampling).
  task automatic run_frame(input int extra_at, output int busy, output int pulses,
                           output int pcycle, output logic [4:0] pidx, output logic pbx,
                           output logic pby, output logic [4:0] idx_first,
                           output logic [4:0] idx_last);
    busy = 0; pulses = 0; pcycle = 0; pidx = '0; pbx = 1'b0; pby = 1'b0;
    idx_first = '1; idx_last = '1;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      if (scan_busy) busy++;
      if (c == 1) idx_first = tgt_idx;
      if (c == 25) idx_last = tgt_idx;
      if (hit_pulse) begin
        pulses++;
        pcycle = c;
        pidx   = hit_idx;
        pbx    = bounce_x;
        pby    = bounce_y;
      end
      frame_tick = (c == extra_at);
      @(negedge clk);
    end
    frame_tick = 1'b0;
  endtask

  int busy, pulses, pcycle;
  logic [4:0] pidx, idx_first, idx_last;
  logic pbx, pby;

  task automatic test_reset();
    rst = 1'b0; clear = 1'b0; frame_tick = 1'b0;
    ball_x = '0; ball_y = '0; ball_size = 10'd8;
    clear_layout();
    #12;
    total++; if (tgt_idx !== 5'd0) begin $display("FAIL reset_tgt_idx got=%0d exp=0", tgt_idx); bad++; end
    total++; if (collision_ball !== 25'd0) begin $display("FAIL reset_coll got=%h exp=0", collision_ball); bad++; end
    total++; if ({hit_pulse, bounce_x, bounce_y, scan_busy, all_cleared, overrun} !== 6'b0 || hit_count !== 5'd0 || hit_idx !== 5'd0) begin
      $display("FAIL reset_flags got=%b cnt=%0d idx=%0d exp=0", {hit_pulse, bounce_x, bounce_y, scan_busy, all_cleared, overrun}, hit_count, hit_idx); bad++; end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_idle_scan();
    clear_layout();
    ball_x = 10'd0; ball_y = 10'd0; ball_size = 10'd8;
    run_frame(0, busy, pulses, pcycle, pidx, pbx, pby, idx_first, idx_last);
    total++; if (busy !== 25) begin $display("FAIL idle_busy got=%0d exp=25", busy); bad++; end
    total++; if (pulses !== 0) begin $display("FAIL idle_pulses got=%0d exp=0", pulses); bad++; end
    total++; if (idx_first !== 5'd0 || idx_last !== 5'd24) begin
      $display("FAIL idle_idx got=%0d/%0d exp=0/24", idx_first, idx_last); bad++; end
    total++; if (collision_ball !== 25'd0) begin $display("FAIL idle_coll got=%h exp=0", collision_ball); bad++; end
  endtask

  task automatic setup_t3();
    clear_layout();
    tx[3] = 10'd100; ty[3] = 10'd40; tw[3] = 10'd60; th[3] = 10'd20;
    ball_size = 10'd8;
    ball_x = 10'd110; ball_y = 10'd20;
    do_clear();
    ball_x = 10'd110; ball_y = 10'd36;
  endtask

  task automatic test_single_hit();
    setup_t3();
    run_frame(0, busy, pulses, pcycle, pidx, pbx, pby, idx_first, idx_last);
    total++; if (pulses !== 1 || pcycle !== 26) begin
      $display("FAIL single_pulse got=%0d@%0d exp=1@26", pulses, pcycle); bad++; end
    total++; if (pidx !== 5'd3) begin $display("FAIL single_idx got=%0d exp=3", pidx); bad++; end
    total++; if (pbx !== 1'b0 || pby !== 1'b1) begin
      $display("FAIL single_bounce got=x%b y%b exp=x0 y1", pbx, pby); bad++; end
    total++; if (collision_ball !== 25'h0000008) begin $display("FAIL single_coll got=%h exp=0000008", collision_ball); bad++; end
    total++; if (hit_count !== 5'd1) begin $display("FAIL single_count got=%0d exp=1", hit_count); bad++; end
  endtask

  task automatic test_priority();
    clear_layout();
    tx[5]  = 10'd200; ty[5]  = 10'd100; tw[5]  = 10'd40; th[5]  = 10'd20;
    tx[21] = 10'd200; ty[21] = 10'd100; tw[21] = 10'd40; th[21] = 10'd20;
    ball_size = 10'd8;
    ball_x = 10'd190; ball_y = 10'd105;
    do_clear();
    ball_x = 10'd196;
    run_frame(0, busy, pulses, pcycle, pidx, pbx, pby, idx_first, idx_last);
    total++; if (pulses !== 1 || pidx !== 5'd5) begin
      $display("FAIL prio_first got=%0d pulses idx=%0d exp=1 idx=5", pulses, pidx); bad++; end
    total++; if (pbx !== 1'b1 || pby !== 1'b0) begin
      $display("FAIL prio_bounce got=x%b y%b exp=x1 y0", pbx, pby); bad++; end
    run_frame(0, busy, pulses, pcycle, pidx, pbx, pby, idx_first, idx_last);
    total++; if (pulses !== 1 || pidx !== 5'd21 || pby !== 1'b1 || pbx !== 1'b0) begin
      $display("FAIL prio_second got=%0d idx=%0d x%b y%b exp=1 idx=21 x0 y1", pulses, pidx, pbx, pby); bad++; end
    total++; if (collision_ball !== 25'h0200020 || hit_count !== 5'd2) begin
      $display("FAIL prio_coll got=%h cnt=%0d exp=0200020 cnt=2", collision_ball, hit_count); bad++; end
  endtask

  task automatic test_removed_and_repeat();
    clear_layout();
    tx[7] = 10'd640; ty[7] = 10'd0; tw[7] = 10'd20; th[7] = 10'd30;
    ball_size = 10'd8;
    ball_x = 10'd636; ball_y = 10'd10;
    do_clear();
    run_frame(0, busy, pulses, pcycle, pidx, pbx, pby, idx_first, idx_last);
    total++; if (pulses !== 0 || collision_ball !== 25'd0) begin
      $display("FAIL removed got=%0d pulses coll=%h exp=0", pulses, collision_ball); bad++; end
    setup_t3();
    run_frame(0, busy, pulses, pcycle, pidx, pbx, pby, idx_first, idx_last);
    total++; if (pulses !== 1 || hit_count !== 5'd1) begin
      $display("FAIL repeat_first got=%0d cnt=%0d exp=1 cnt=1", pulses, hit_count); bad++; end
    run_frame(0, busy, pulses, pcycle, pidx, pbx, pby, idx_first, idx_last);
    total++; if (pulses !== 0 || hit_count !== 5'd1 || collision_ball !== 25'h0000008) begin
      $display("FAIL repeat_second got=%0d cnt=%0d coll=%h exp=0 cnt=1 coll=0000008", pulses, hit_count, collision_ball); bad++; end
  endtask

  task automatic test_overrun();
    setup_t3();
    run_frame(10, busy, pulses, pcycle, pidx, pbx, pby, idx_first, idx_last);
    total++; if (busy !== 25 || pulses !== 1 || pcycle !== 26) begin
      $display("FAIL ovr_scan got=busy%0d pulses%0d@%0d exp=busy25 pulses1@26", busy, pulses, pcycle); bad++; end
    total++; if (overrun !== 1'b1) begin $display("FAIL ovr_flag got=%b exp=1", overrun); bad++; end
    do_clear();
    total++; if (collision_ball !== 25'd0 || hit_count !== 5'd0 || overrun !== 1'b0 || scan_busy !== 1'b0) begin
      $display("FAIL ovr_clear got=coll%h cnt%0d ovr%b busy%b exp=0", collision_ball, hit_count, overrun, scan_busy); bad++; end
    clear_layout();
    run_frame(0, busy, pulses, pcycle, pidx, pbx, pby, idx_first, idx_last);
    total++; if (busy !== 25 || overrun !== 1'b0) begin
      $display("FAIL ovr_after got=busy%0d ovr%b exp=busy25 ovr0", busy, overrun); bad++; end
  endtask

  task automatic test_reset_midscan();
    setup_t3();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (scan_busy !== 1'b0 || tgt_idx !== 5'd0) begin
      $display("FAIL rst_mid got=busy%b idx%0d exp=busy0 idx0", scan_busy, tgt_idx); bad++; end
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (hit_pulse) pulses++;
      @(negedge clk);
    end
    total++; if (pulses !== 0 || collision_ball !== 25'd0 || hit_count !== 5'd0) begin
      $display("FAIL rst_commit got=pulses%0d coll%h cnt%0d exp=0", pulses, collision_ball, hit_count); bad++; end
  endtask

  task automatic test_all_clear();
    clear_layout();
    for (int i = 0; i < 25; i++) begin
      tx[i] = 10'd296; ty[i] = 10'd296; tw[i] = 10'd16; th[i] = 10'd16;
    end
    ball_size = 10'd8;
    ball_x = 10'd300; ball_y = 10'd300;
    do_clear();
    for (int k = 0; k < 25; k++) begin
      run_frame(0, busy, pulses, pcycle, pidx, pbx, pby, idx_first, idx_last);
      total++; if (pulses !== 1 || pidx !== 5'(k)) begin
        $display("FAIL all_frame%0d got=%0d idx=%0d exp=1 idx=%0d", k, pulses, pidx, k); bad++; end
      if (k == 23) begin
        total++; if (all_cleared !== 1'b0 || hit_count !== 5'd24) begin
          $display("FAIL all_early got=ac%b cnt%0d exp=ac0 cnt24", all_cleared, hit_count); bad++; end
      end
    end
    total++; if (hit_count !== 5'd25 || all_cleared !== 1'b1 || collision_ball !== 25'h1ffffff) begin
      $display("FAIL all_done got=cnt%0d ac%b coll%h exp=cnt25 ac1 coll1ffffff", hit_count, all_cleared, collision_ball); bad++; end
    run_frame(0, busy, pulses, pcycle, pidx, pbx, pby, idx_first, idx_last);
    total++; if (busy !== 25 || pulses !== 0 || hit_count !== 5'd25) begin
      $display("FAIL all_extra got=busy%0d pulses%0d cnt%0d exp=busy25 pulses0 cnt25", busy, pulses, hit_count); bad++; end
    @(negedge clk);
    clear = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    frame_tick = 1'b0;
    total++; if (all_cleared !== 1'b0 || hit_count !== 5'd0 || scan_busy !== 1'b0) begin
      $display("FAIL clr_tick got=ac%b cnt%0d busy%b exp=0", all_cleared, hit_count, scan_busy); bad++; end
    @(negedge clk);
    total++; if (scan_busy !== 1'b0 || tgt_idx !== 5'd0) begin
      $display("FAIL clr_tick_idle got=busy%b idx%0d exp=busy0 idx0", scan_busy, tgt_idx); bad++; end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_single_hit();
    test_priority();
    test_removed_and_repeat();
    test_overrun();
    test_reset_midscan();
    test_all_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
